// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// mips_ctrl_pkg: opcodes, datapath mux encodings and FSM states. Rev 1.0
// ==========================================================================
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_SHIFT = 6'b110000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_EXEC_R   = 4'd2;
  localparam logic [3:0] ST_R_WB     = 4'd3;
  localparam logic [3:0] ST_EXEC_I   = 4'd4;
  localparam logic [3:0] ST_I_WB     = 4'd5;
  localparam logic [3:0] ST_MEM_ADDR = 4'd6;
  localparam logic [3:0] ST_MEM_RD   = 4'd7;
  localparam logic [3:0] ST_MEM_WB   = 4'd8;
  localparam logic [3:0] ST_MEM_WR   = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;

  // Unknown opcodes map back to FETCH, which doubles as the illegal marker.
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    logic [3:0] st;
    case (op)
      OP_R, OP_SHIFT:   st = ST_EXEC_R;
      OP_ADDI, OP_ANDI: st = ST_EXEC_I;
      OP_LW, OP_SW:     st = ST_MEM_ADDR;
      OP_BEQ:           st = ST_BRANCH;
      OP_J:             st = ST_JUMP;
      default:          st = ST_FETCH;
    endcase
    return st;
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return decode_target(op) != ST_FETCH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ==========================================================================
// multicycle_control: multicycle control FSM with memory wait timeout. Rev 1.0
// ==========================================================================
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_W        = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic [3:0]          state_o
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((2 ** WAIT_W) - 2);

  logic [3:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [5:0]          op_in, op_lat;
  logic                mem_rdy, in_wait, timeout;

  assign op_in   = 6'(opcode);
  assign op_lat  = 6'(op_q);
  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  // wait_q counts earlier misses, so this fires on the (2^WAIT_W-1)th miss in a row.
  assign timeout = in_wait && !mem_rdy && (wait_q == WAIT_LAST);

  always_comb begin
    wait_d = '0;
    if (in_wait && !mem_rdy && !timeout) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_rdy) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d    = opcode;
        state_d = decode_target(op_in);
      end
      ST_EXEC_R:   state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (op_lat == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (mem_rdy)      state_d = ST_MEM_WB;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR: begin
        if (mem_rdy || timeout) state_d = ST_FETCH;
      end
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = SRCB_FOUR;
        ir_write    = mem_rdy;
        pc_write    = mem_rdy;
        mem_timeout = timeout;
      end
      ST_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal_op = !op_legal(op_in);
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        alu_src_b = (op_lat == OP_SHIFT) ? SRCB_IMM : SRCB_B;
      end
      ST_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (op_lat == OP_ANDI) ? ALU_AND : ALU_ADD;
      end
      ST_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read    = 1'b1;
        iord        = 1'b1;
        mem_timeout = timeout;
      end
      ST_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write   = 1'b1;
        iord        = 1'b1;
        instr_done  = mem_rdy;
        mem_timeout = timeout;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ==========================================================================
// tb_multicycle_control: scoreboard bench for multicycle_control. Rev 1.0
// ==========================================================================
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, SH = 6'b110000;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       rdy_b = 1'b0;

  logic pw_a, pwc_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, asa_a, done_a, ill_a, to_a;
  logic pw_b, pwc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, asa_b, done_b, ill_b, to_b;
  logic [1:0] asb_a, aop_a, pcs_a, asb_b, aop_b, pcs_b;
  logic [3:0] st_a, st_b;
  logic [22:0] act_a, act_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(1'b1), .WAIT_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw_a), .pc_write_cond(pwc_a), .iord(iord_a), .mem_read(mr_a),
    .mem_write(mw_a), .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rd_a),
    .reg_write(rw_a), .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a),
    .pc_source(pcs_a), .instr_done(done_a), .illegal_op(ill_a),
    .mem_timeout(to_a), .state_o(st_a)
  );

  multicycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(1'b0), .WAIT_W(4)) u_nohs (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(rdy_b),
    .pc_write(pw_b), .pc_write_cond(pwc_b), .iord(iord_b), .mem_read(mr_b),
    .mem_write(mw_b), .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rd_b),
    .reg_write(rw_b), .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b),
    .pc_source(pcs_b), .instr_done(done_b), .illegal_op(ill_b),
    .mem_timeout(to_b), .state_o(st_b)
  );

  assign act_a = {st_a, pw_a, pwc_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, asa_a,
                  asb_a, aop_a, pcs_a, done_a, ill_a, to_a};
  assign act_b = {st_b, pw_b, pwc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, asa_b,
                  asb_b, aop_b, pcs_b, done_b, ill_b, to_b};

  // Vector: {state, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill, tmo}
  function automatic logic [22:0] v(input logic [3:0] st, input logic [9:0] b, input logic [1:0] asb,
                                    input logic [1:0] aop, input logic [1:0] pcs, input logic [2:0] p);
    return {st, b, asb, aop, pcs, p};
  endfunction

  function automatic logic [22:0] e_fetch(input logic r, input logic t);
    return v(ST_FETCH, {r, 2'b00, 1'b1, 1'b0, r, 4'b0000}, 2'b01, 2'b00, 2'b00, {2'b00, t});
  endfunction
  function automatic logic [22:0] e_decode(input logic ill);
    return v(ST_DECODE, 10'b0, 2'b11, 2'b00, 2'b00, {1'b0, ill, 1'b0});
  endfunction
  function automatic logic [22:0] e_exr(input logic sh);
    return v(ST_EXEC_R, 10'b0000000001, sh ? 2'b10 : 2'b00, 2'b10, 2'b00, 3'b000);
  endfunction
  function automatic logic [22:0] e_rwb();
    return v(ST_R_WB, 10'b0000000110, 2'b00, 2'b00, 2'b00, 3'b100);
  endfunction
  function automatic logic [22:0] e_exi(input logic an);
    return v(ST_EXEC_I, 10'b0000000001, 2'b10, an ? 2'b11 : 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [22:0] e_iwb();
    return v(ST_I_WB, 10'b0000000010, 2'b00, 2'b00, 2'b00, 3'b100);
  endfunction
  function automatic logic [22:0] e_madr();
    return v(ST_MEM_ADDR, 10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [22:0] e_mrd(input logic t);
    return v(ST_MEM_RD, 10'b0011000000, 2'b00, 2'b00, 2'b00, {2'b00, t});
  endfunction
  function automatic logic [22:0] e_mwb();
    return v(ST_MEM_WB, 10'b0000001010, 2'b00, 2'b00, 2'b00, 3'b100);
  endfunction
  function automatic logic [22:0] e_mwr(input logic r, input logic t);
    return v(ST_MEM_WR, 10'b0010100000, 2'b00, 2'b00, 2'b00, {r, 1'b0, t});
  endfunction
  function automatic logic [22:0] e_br();
    return v(ST_BRANCH, 10'b0100000001, 2'b00, 2'b01, 2'b01, 3'b100);
  endfunction
  function automatic logic [22:0] e_jmp();
    return v(ST_JUMP, 10'b1000000000, 2'b00, 2'b00, 2'b10, 3'b100);
  endfunction

  typedef struct {
    logic        rn;
    logic        rdy;
    logic [5:0]  op;
    logic [22:0] vec;
    logic        nh;
  } ent_t;

  ent_t  sb_q[$];
  string tag_q[$];

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (#%0d): got %h expected %h", tag, n_cmp, got, exp);
    end
  endtask

  task automatic p(input string tag, input logic rn, input logic rdy, input logic [5:0] op,
                   input logic [22:0] vec, input logic nh);
    ent_t e;
    e.rn = rn; e.rdy = rdy; e.op = op; e.vec = vec; e.nh = nh;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic rst2();
    p("rst0", 1'b0, 1'b0, RT, e_fetch(1'b0, 1'b0), 1'b0);
    p("rst1", 1'b0, 1'b0, RT, e_fetch(1'b0, 1'b0), 1'b0);
  endtask

  // Each entry drives one cycle's inputs at the falling edge and is checked before the rising edge.
  task automatic drain();
    while (sb_q.size() > 0) begin
      ent_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      reset_n   = e.rn;
      mem_ready = e.rdy;
      opcode    = e.op;
      #2;
      chk(t, act_a, e.vec);
      if (e.nh) chk({t, "/nohs"}, act_b, e.vec);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Back-to-back instructions with memory always ready; the no-handshake copy must match.
    rst2();
    p("lw.f", 1, 1, LW, e_fetch(1, 0), 1);   p("lw.d", 1, 1, LW, e_decode(0), 1);
    p("lw.a", 1, 1, LW, e_madr(), 1);         p("lw.r", 1, 1, LW, e_mrd(0), 1);
    p("lw.wb", 1, 1, LW, e_mwb(), 1);
    p("add.f", 1, 1, RT, e_fetch(1, 0), 1);  p("add.d", 1, 1, RT, e_decode(0), 1);
    p("add.x", 1, 1, RT, e_exr(0), 1);        p("add.wb", 1, 1, RT, e_rwb(), 1);
    p("sh.f", 1, 1, SH, e_fetch(1, 0), 1);   p("sh.d", 1, 1, SH, e_decode(0), 1);
    p("sh.x", 1, 1, SH, e_exr(1), 1);         p("sh.wb", 1, 1, SH, e_rwb(), 1);
    p("addi.f", 1, 1, ADDI, e_fetch(1, 0), 1); p("addi.d", 1, 1, ADDI, e_decode(0), 1);
    p("addi.x", 1, 1, ADDI, e_exi(0), 1);      p("addi.wb", 1, 1, ADDI, e_iwb(), 1);
    p("andi.f", 1, 1, ANDI, e_fetch(1, 0), 1); p("andi.d", 1, 1, ANDI, e_decode(0), 1);
    p("andi.x", 1, 1, ANDI, e_exi(1), 1);      p("andi.wb", 1, 1, ANDI, e_iwb(), 1);
    p("sw.f", 1, 1, SW, e_fetch(1, 0), 1);   p("sw.d", 1, 1, SW, e_decode(0), 1);
    p("sw.a", 1, 1, SW, e_madr(), 1);         p("sw.w", 1, 1, SW, e_mwr(1, 0), 1);
    p("beq.f", 1, 1, BEQ, e_fetch(1, 0), 1); p("beq.d", 1, 1, BEQ, e_decode(0), 1);
    p("beq.b", 1, 1, BEQ, e_br(), 1);
    p("j.f", 1, 1, JMP, e_fetch(1, 0), 1);   p("j.d", 1, 1, JMP, e_decode(0), 1);
    p("j.j", 1, 1, JMP, e_jmp(), 1);
    p("ill.f", 1, 1, BAD, e_fetch(1, 0), 1); p("ill.d", 1, 1, BAD, e_decode(1), 1);
    p("ill.ret", 1, 0, RT, e_fetch(0, 0), 0);

    // Reset asserted during EXEC_R, then an sw stalled three cycles in MEM_WR.
    p("mid.f", 1, 1, RT, e_fetch(1, 0), 0);  p("mid.d", 1, 1, RT, e_decode(0), 0);
    p("mid.x", 1, 1, RT, e_exr(0), 0);
    p("mid.rst", 0, 0, RT, e_fetch(0, 0), 0);
    p("mid.post", 1, 0, RT, e_fetch(0, 0), 0);
    p("sww.f", 1, 1, SW, e_fetch(1, 0), 0);  p("sww.d", 1, 1, SW, e_decode(0), 0);
    p("sww.a", 1, 1, SW, e_madr(), 0);
    for (int i = 0; i < 3; i++) p("sww.wait", 1, 0, SW, e_mwr(0, 0), 0);
    p("sww.done", 1, 1, SW, e_mwr(1, 0), 0);
    p("sww.ret", 1, 0, SW, e_fetch(0, 0), 0);

    // Timeouts in FETCH, MEM_RD and MEM_WR, plus ready arriving on the expiry cycle.
    rst2();
    for (int i = 0; i < 14; i++) p("tf.wait", 1, 0, LW, e_fetch(0, 0), 0);
    p("tf.tmo", 1, 0, LW, e_fetch(0, 1), 0);
    p("tf.again", 1, 0, LW, e_fetch(0, 0), 0);
    p("race.f", 1, 1, LW, e_fetch(1, 0), 0); p("race.d", 1, 1, LW, e_decode(0), 0);
    p("race.a", 1, 1, LW, e_madr(), 0);
    for (int i = 0; i < 14; i++) p("race.wait", 1, 0, LW, e_mrd(0), 0);
    p("race.rdy", 1, 1, LW, e_mrd(0), 0);
    p("race.wb", 1, 1, LW, e_mwb(), 0);
    p("trd.f", 1, 1, LW, e_fetch(1, 0), 0);  p("trd.d", 1, 1, LW, e_decode(0), 0);
    p("trd.a", 1, 1, LW, e_madr(), 0);
    for (int i = 0; i < 14; i++) p("trd.wait", 1, 0, LW, e_mrd(0), 0);
    p("trd.tmo", 1, 0, LW, e_mrd(1), 0);
    p("twr.f", 1, 1, SW, e_fetch(1, 0), 0);  p("twr.d", 1, 1, SW, e_decode(0), 0);
    p("twr.a", 1, 1, SW, e_madr(), 0);
    for (int i = 0; i < 14; i++) p("twr.wait", 1, 0, SW, e_mwr(0, 0), 0);
    p("twr.tmo", 1, 0, SW, e_mwr(0, 1), 0);
    p("twr.ret", 1, 0, SW, e_fetch(0, 0), 0);

    @(negedge clk);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
